// File: rtl/div_unit.sv
// Iterative restoring divider for MIPS DIV/DIVU: one quotient bit per clock.
// result_o = {remainder, quotient}, held with ready_o until start_i drops.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BY_ZERO = 2'd1,
        ON      = 2'd2,
        END     = 2'd3
    } state_t;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    state_t             state_r, state_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic [WIDTH-1:0]   dvd_r, dvd_s;      // dividend magnitude, becomes quotient
    logic [WIDTH-1:0]   dvs_r, dvs_s;      // divisor magnitude
    logic [WIDTH-1:0]   rem_r, rem_s;
    logic               neg_q_r, neg_q_s;
    logic               neg_rem_r, neg_rem_s;
    logic [2*WIDTH-1:0] result_r, result_s;
    logic               ready_r, ready_s;

    logic [WIDTH:0]     rem_shift_s;
    logic [WIDTH-1:0]   rem_diff_s;
    logic               ge_s;

    // Next-state, datapath step and output computation.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        dvd_s       = dvd_r;
        dvs_s       = dvs_r;
        rem_s       = rem_r;
        neg_q_s     = neg_q_r;
        neg_rem_s   = neg_rem_r;
        result_s    = result_r;
        ready_s     = ready_r;

        rem_shift_s = {rem_r, dvd_r[WIDTH-1]};
        ge_s        = (rem_shift_s >= {1'b0, dvs_r});
        // When ge_s holds the true difference is below dvs_r, so WIDTH bits suffice.
        rem_diff_s  = rem_shift_s[WIDTH-1:0] - dvs_r;

        case (state_r)
            IDLE: begin
                ready_s = 1'b0;
                if (start_i && !annul_i) begin
                    neg_q_s   = signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                    neg_rem_s = signed_div_i & opdata1_i[WIDTH-1];
                    dvd_s     = (signed_div_i && opdata1_i[WIDTH-1]) ? negate(opdata1_i) : opdata1_i;
                    dvs_s     = (signed_div_i && opdata2_i[WIDTH-1]) ? negate(opdata2_i) : opdata2_i;
                    rem_s     = {WIDTH{1'b0}};
                    cnt_s     = {CNT_W{1'b0}};
                    if (opdata2_i == {WIDTH{1'b0}}) begin
                        state_s = BY_ZERO;
                    end else begin
                        state_s = ON;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            BY_ZERO: begin
                state_s  = END;
                result_s = {(2*WIDTH){1'b0}};
                ready_s  = 1'b1;
            end
            ON: begin
                ready_s = 1'b0;
                if (annul_i) begin
                    state_s = IDLE;
                end else if (cnt_r == CNT_W'(WIDTH)) begin
                    result_s = {(neg_rem_r ? negate(rem_r) : rem_r),
                                (neg_q_r   ? negate(dvd_r) : dvd_r)};
                    ready_s  = 1'b1;
                    state_s  = END;
                end else begin
                    rem_s = ge_s ? rem_diff_s : rem_shift_s[WIDTH-1:0];
                    dvd_s = {dvd_r[WIDTH-2:0], ge_s};
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            END: begin
                if (start_i) begin
                    ready_s = 1'b1;
                    state_s = END;
                end else begin
                    ready_s = 1'b0;
                    state_s = IDLE;
                end
            end
            default: begin
                ready_s = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            dvd_r     <= {WIDTH{1'b0}};
            dvs_r     <= {WIDTH{1'b0}};
            rem_r     <= {WIDTH{1'b0}};
            neg_q_r   <= 1'b0;
            neg_rem_r <= 1'b0;
            result_r  <= {(2*WIDTH){1'b0}};
            ready_r   <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            dvd_r     <= dvd_s;
            dvs_r     <= dvs_s;
            rem_r     <= rem_s;
            neg_q_r   <= neg_q_s;
            neg_rem_r <= neg_rem_s;
            result_r  <= result_s;
            ready_r   <= ready_s;
        end
    end

    assign result_o = result_r;
    assign ready_o  = ready_r;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: expected {rem, quot} are queued at issue and
// compared when ready_o rises, together with latency and handshake behaviour.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int total = 0;
    int bad   = 0;
    logic [63:0] sb_q[$];

    div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
        .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
        .start_i(start_i), .annul_i(annul_i),
        .result_o(result_o), .ready_o(ready_o)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        if (b == 32'd0) begin
            q = 32'd0; r = 32'd0;
        end else if (!sgn) begin
            q = a / b; r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = 32'd0;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
        return {r, q};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one divide, measure latency, check result, optionally scramble
    // operands after accept, and hold start_i for 'hold' cycles past ready.
    task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input int lat, input bit scramble, input int hold);
        int n;
        logic [63:0] exp;
        @(negedge clk);
        signed_div_i = sgn; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
        sb_q.push_back(model(sgn, a, b));
        n = 0;
        for (int e = 1; e <= 60; e++) begin
            @(posedge clk); #1;
            if (e == 1 && scramble) begin
                opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = ~sgn;
            end
            if (ready_o) begin
                n = e;
                break;
            end
        end
        exp = sb_q.pop_front();
        chk({tag, "_lat"}, 64'(n), 64'(lat));
        chk({tag, "_res"}, result_o, exp);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_rdy"}, 64'(ready_o), 64'd1);
            chk({tag, "_hold_res"}, result_o, exp);
        end
        @(negedge clk); start_i = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_drop_rdy"}, 64'(ready_o), 64'd0);
        chk({tag, "_drop_res"}, result_o, exp);
    endtask

    initial begin
        bit seen;
        logic [63:0] held;
        rst = 1'b0; signed_div_i = 1'b0; opdata1_i = 32'd0; opdata2_i = 32'd0;
        start_i = 1'b0; annul_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdy", 64'(ready_o), 64'd0);
        chk("rst_res", result_o, 64'd0);
        @(negedge clk); rst = 1'b1;

        do_div("u100_7",   1'b0, 32'd100,         32'd7,          34, 1'b0, 5);
        do_div("s_m7_2",   1'b1, 32'hFFFF_FFF9,   32'd2,          34, 1'b0, 0);
        do_div("u_ff_2",   1'b0, 32'hFFFF_FFFF,   32'd2,          34, 1'b0, 0);
        do_div("u5_0",     1'b0, 32'd5,           32'd0,           2, 1'b0, 0);
        do_div("s_ovf",    1'b1, 32'h8000_0000,   32'hFFFF_FFFF,  34, 1'b0, 0);
        do_div("s5_0",     1'b1, 32'd5,           32'd0,           2, 1'b0, 0);
        do_div("s_1000_m3",1'b1, 32'd1000,        32'hFFFF_FFFD,  34, 1'b1, 0);

        // start and annul together in IDLE: a zero divisor would show ready on edge 2
        @(negedge clk);
        opdata1_i = 32'd7; opdata2_i = 32'd0; start_i = 1'b1; annul_i = 1'b1;
        seen = 1'b0;
        repeat (4) begin @(posedge clk); #1; if (ready_o) seen = 1'b1; end
        chk("start_annul_idle", 64'(seen), 64'd0);
        @(negedge clk); start_i = 1'b0; annul_i = 1'b0;

        // annul at iteration 10 of 100/7
        @(negedge clk);
        signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
        held = result_o;
        repeat (11) @(posedge clk);
        @(negedge clk); annul_i = 1'b1; start_i = 1'b0;
        @(negedge clk); annul_i = 1'b0;
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (ready_o) seen = 1'b1; end
        chk("annul_no_rdy", 64'(seen), 64'd0);
        chk("annul_res_kept", result_o, held);
        do_div("u9_3", 1'b0, 32'd9, 32'd3, 34, 1'b0, 0);

        for (int k = 0; k < 4; k++) begin
            do_div("rand", k[0], $urandom, $urandom_range(1, 32'h00FF_FFFF), 34, 1'b0, 0);
        end

        do_div("u77_5", 1'b0, 32'd77, 32'd5, 34, 1'b0, 0);
        // asynchronous reset between edges while in ON
        @(negedge clk);
        signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
        repeat (6) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("async_rst_rdy", 64'(ready_o), 64'd0);
        chk("async_rst_res", result_o, 64'd0);
        start_i = 1'b0;
        @(negedge clk); rst = 1'b1;
        do_div("u12_4", 1'b0, 32'd12, 32'd4, 34, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative multi-cycle divider for MIPS DIV/DIVU, sitting beside the EX stage of the 5-stage pipeline.
- EX raises start_i with operands; the pipeline-control block stalls IF/ID/EX until ready_o rises.
- The result is written into the HI/LO registers via the MEM/WB path: HI = remainder, LO = quotient.
- One restoring-division step per clock; each operation is independent of the last.

Parameters:
WIDTH, 32, operand width in bits; the counter and internal registers scale with it.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
signed_div_i  input  1  1 = signed DIV, 0 = unsigned DIVU; sampled at accept
opdata1_i  input  WIDTH  dividend; sampled at accept
opdata2_i  input  WIDTH  divisor; sampled at accept
start_i  input  1  request from EX; held high until ready_o seen, then dropped
annul_i  input  1  cancel from pipeline flush (branch/exception)
result_o  output  2*WIDTH  {remainder, quotient}: high half goes to HI, low half to LO
ready_o  output  1  result valid

Behaviour:
- Reset (rst=0, any time, asynchronous): state=IDLE, ready_o=0, result_o=0, counter=0, internal operand registers=0. Reset mid-operation discards all work.
- States: IDLE, BY_ZERO, ON, END.
- IDLE:
  - start_i=1 and annul_i=0 -> accept: latch signed_div_i and both operands.
  - If divisor==0 -> BY_ZERO, else -> ON with counter=0.
  - Otherwise stay; ready_o=0.
- BY_ZERO: unconditionally -> END with result_o=0 (quotient 0, remainder 0).
- ON:
  - annul_i=1 -> IDLE immediately; ready_o stays 0; result_o unchanged.
  - Else perform one step: shift the partial remainder left by one, bringing in the next dividend MSB; subtract |divisor|; if the difference is non-negative, keep it and set the quotient bit to 1, else set the bit to 0. Counter increments.
  - After WIDTH steps -> END.
- Entering END:
  - Apply sign correction (signed mode only); register result_o; set ready_o=1.
- END:
  - Hold ready_o=1 and result_o while start_i=1.
  - start_i=0 -> IDLE, ready_o=0; result_o holds its last value.
  - annul_i is ignored in END.
- Signed mode:
  - Operate on magnitudes.
  - Negate the quotient if the dividend and divisor MSBs differ.
  - The remainder takes the sign of the dividend.
- Unsigned mode: no correction.
- Overflow: signed -2^(WIDTH-1) / -1 -> quotient 0x80000000 (two's-complement wrap), remainder 0, normal latency. No trap.
- Latency:
  - Nonzero divisor: ready_o rises on the (WIDTH+2)th rising edge after the accepting edge, counting the accept edge as edge 1. For WIDTH=32 this is 34 edges.
  - Zero divisor: ready_o rises on edge 2.
- Operand changes after accept have no effect. A new start_i is only accepted from IDLE, so back-to-back divides need start_i low for at least one cycle.
- start_i and annul_i both high in IDLE -> not accepted.

Test Plan:
- Unsigned 100/7: start_i=1 with opdata1=100, opdata2=7 -> ready_o=1 exactly 34 edges after accept; result_o={32'd2, 32'd14}.
- Signed -7/2: opdata1=0xFFFFFFF9, opdata2=2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1). Unsigned 0xFFFFFFFF/2 -> quotient 0x7FFFFFFF, remainder 1.
- Divide by zero (5/0), both modes -> ready_o on edge 2; result_o=0. Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0.
- annul_i pulsed at iteration 10 of 100/7 -> back to IDLE; ready_o never rises. Then issue 9/3 -> correct {0, 3} with full latency.
- Handshake: hold start_i 5 cycles past ready_o -> ready_o and result_o stable all 5 cycles. Drop start_i -> ready_o=0 on the next edge. Change operands during ON -> result unaffected.
- Reset: drive rst=0 asynchronously mid-ON (between edges) -> ready_o and result_o go to 0 immediately. After release, 12/4 -> {0, 3}.
